// File: rtl/packet_to_mii_tx_pkg.sv
// Shared definitions for the packet-to-MII transmitter.
// Contents: transmit FSM state encoding, preamble/SFD byte values,
// CRC-32 polynomial and seed, and a bit-reversal helper used to derive
// the LSB-first (reflected) form of the polynomial.
package packet_to_mii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          FCS_LEN       = 4;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 (Ethernet FCS) accumulator, LSB-first bit order.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads the seed
//   init  - reload the seed (has priority over en)
//   en    - fold data into the running CRC this cycle
//   data  - byte to fold in
//   crc   - running (non-inverted) CRC register
module crc32_d8
  import packet_to_mii_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  function automatic logic [31:0] next_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= next_crc(crc, data);
  end

endmodule

// File: rtl/packet_to_mii_tx.sv
// Reads packets from a packet memory and transmits them as MII-style frames:
// 7x preamble, SFD, payload, zero pad up to the minimum frame, 4-byte FCS,
// then an inter-frame gap.
// Ports:
//   iclk, i_rst_n      - clock, asynchronous active-low reset
//   ipkt_valid/len     - head-of-queue packet present / its length
//   opkt_pop           - one-cycle pulse consuming the head length entry
//   ord_en, ird_data   - memory read strobe / data (1-cycle read latency)
//   otx_en/otx_d/otx_er- transmit bus (otx_er tied low)
//   odrop              - pulse when a packet with illegal length is discarded
//   obusy              - high whenever the FSM is not idle
module packet_to_mii_tx
  import packet_to_mii_tx_pkg::*;
#(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pMIN_FRAME         = 60,
  parameter int pIFG               = 12,
  parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT)
)(
  input  logic                   iclk,
  input  logic                   i_rst_n,
  input  logic                   ipkt_valid,
  input  logic [pLEN_WIDTH-1:0]  ipkt_len,
  output logic                   opkt_pop,
  output logic                   ord_en,
  input  logic [pDATA_WIDTH-1:0] ird_data,
  output logic                   otx_en,
  output logic [pDATA_WIDTH-1:0] otx_d,
  output logic                   otx_er,
  output logic                   odrop,
  output logic                   obusy
);

  localparam logic [pLEN_WIDTH-1:0] MAX_LEN  = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
  localparam logic [pLEN_WIDTH-1:0] MIN_LEN  = pLEN_WIDTH'(pMIN_FRAME);
  localparam logic [pLEN_WIDTH-1:0] PRE_LAST = pLEN_WIDTH'(PREAMBLE_LEN - 1);
  localparam logic [pLEN_WIDTH-1:0] FCS_LAST = pLEN_WIDTH'(FCS_LEN - 1);
  // Outputs lag the state by one register stage, so the IDLE and PREAMBLE
  // cycles of the next frame already contribute one bus cycle of gap; the
  // IFG state itself therefore lasts pIFG-1 cycles.
  localparam logic [pLEN_WIDTH-1:0] IFG_LAST = pLEN_WIDTH'(pIFG - 2);

  tx_state_t             state;
  logic [pLEN_WIDTH-1:0] cnt;
  logic [pLEN_WIDTH-1:0] len_q;
  logic                  data_last;
  logic [31:0]           crc;
  logic [31:0]           fcs;
  logic [7:0]            fcs_byte;
  logic                  crc_init;
  logic                  crc_en;
  logic [7:0]            crc_d;

  assign data_last = (cnt == len_q - 1'b1);

  // Read one byte ahead of the bus: the SFD cycle fetches byte 0, and the
  // final DATA cycle issues no read, giving exactly len strobes.
  assign ord_en = (state == ST_SFD) || ((state == ST_DATA) && !data_last);
  assign obusy  = (state != ST_IDLE);
  assign otx_er = 1'b0;

  assign crc_init = (state == ST_IDLE);
  assign crc_en   = (state == ST_DATA) || (state == ST_PAD);
  assign crc_d    = (state == ST_DATA) ? ird_data[7:0] : 8'h00;

  crc32_d8 u_crc (
    .clk   (iclk),
    .rst_n (i_rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (crc_d),
    .crc   (crc)
  );

  always_comb begin
    fcs      = ~crc;
    fcs_byte = fcs[7:0];
    case (cnt[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      otx_en   <= 1'b0;
      otx_d    <= '0;
      opkt_pop <= 1'b0;
      odrop    <= 1'b0;
    end else begin
      opkt_pop <= 1'b0;
      odrop    <= 1'b0;
      case (state)
        ST_IDLE: begin
          otx_en <= 1'b0;
          otx_d  <= '0;
          cnt    <= '0;
          // The memory sees our pop one cycle late, so ipkt_valid is stale
          // while opkt_pop is high; ignore it for that cycle.
          if (ipkt_valid && !opkt_pop) begin
            opkt_pop <= 1'b1;
            len_q    <= ipkt_len;
            if ((ipkt_len == '0) || (ipkt_len > MAX_LEN)) odrop <= 1'b1;
            else                                          state <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          otx_en <= 1'b1;
          otx_d  <= pDATA_WIDTH'(PREAMBLE_BYTE);
          if (cnt == PRE_LAST) begin
            state <= ST_SFD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SFD: begin
          otx_en <= 1'b1;
          otx_d  <= pDATA_WIDTH'(SFD_BYTE);
          state  <= ST_DATA;
          cnt    <= '0;
        end
        ST_DATA: begin
          otx_en <= 1'b1;
          otx_d  <= ird_data;
          if (data_last) begin
            if (len_q < MIN_LEN) begin
              // Keep counting through PAD so it ends at the minimum frame size.
              state <= ST_PAD;
              cnt   <= cnt + 1'b1;
            end else begin
              state <= ST_FCS;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PAD: begin
          otx_en <= 1'b1;
          otx_d  <= '0;
          if (cnt == MIN_LEN - 1'b1) begin
            state <= ST_FCS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FCS: begin
          otx_en <= 1'b1;
          otx_d  <= pDATA_WIDTH'(fcs_byte);
          if (cnt == FCS_LAST) begin
            state <= ST_IFG;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IFG: begin
          otx_en <= 1'b0;
          otx_d  <= '0;
          if (cnt == IFG_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          otx_en <= 1'b0;
          otx_d  <= '0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_to_mii_tx.sv
// Testbench for packet_to_mii_tx: packet memory model, bus monitor and a
// frame-level reference model (preamble/SFD, pad to 60, table-driven CRC-32).
`timescale 1ns/1ps
module tb_packet_to_mii_tx;
  localparam int LW = 11;

  logic          iclk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          ipkt_valid = 1'b0;
  logic [LW-1:0] ipkt_len = '0;
  logic [7:0]    ird_data = '0;
  logic          opkt_pop, ord_en, otx_en, otx_er, odrop, obusy;
  logic [7:0]    otx_d;

  int tests = 0;
  int fails = 0;

  packet_to_mii_tx dut (
    .iclk(iclk), .i_rst_n(i_rst_n), .ipkt_valid(ipkt_valid), .ipkt_len(ipkt_len),
    .opkt_pop(opkt_pop), .ord_en(ord_en), .ird_data(ird_data), .otx_en(otx_en),
    .otx_d(otx_d), .otx_er(otx_er), .odrop(odrop), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  // Packet memory: length FIFO plus a flat byte stream of legal packets.
  logic [LW-1:0] lenq[$];
  logic [7:0]    memq[$];
  logic [7:0]    rd_b;
  int            underrun = 0;

  always @(posedge iclk) begin
    if (ord_en) begin
      if (memq.size() > 0) begin
        rd_b = memq.pop_front();
        ird_data <= rd_b;
      end else underrun++;
    end
    if (opkt_pop && lenq.size() > 0) void'(lenq.pop_front());
  end

  // Bus monitor, sampled on the falling edge.
  int   cyc = 0, strobes = 0, drops = 0, pops = 0, frames_done = 0;
  int   low_run = 0, last_gap = -1, er_seen = 0, pop_cyc = 0, lat = -1;
  logic in_frame = 1'b0, seen_frame = 1'b0;
  logic [7:0] cap[$];
  logic [7:0] last_frame[$];

  always @(negedge iclk) begin
    cyc++;
    ipkt_valid = (lenq.size() != 0);
    ipkt_len   = ipkt_valid ? lenq[0] : '0;
    if (ord_en) strobes++;
    if (odrop) drops++;
    if (opkt_pop) begin pops++; pop_cyc = cyc; end
    if (otx_er) er_seen++;
    if (otx_en) begin
      if (!in_frame) begin
        lat = cyc - pop_cyc;
        if (seen_frame) last_gap = low_run;
      end
      in_frame = 1'b1;
      cap.push_back(otx_d);
      low_run = 0;
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        seen_frame = 1'b1;
        last_frame = cap;
        cap.delete();
        frames_done++;
      end
      low_run++;
    end
  end

  // Reference model
  logic [31:0] crc_tbl[256];

  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic build_frame(input logic [7:0] d[$], output logic [7:0] f[$]);
    logic [7:0]  body[$];
    logic [31:0] c;
    f = {};
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    body = d;
    while (body.size() < 60) body.push_back(8'h00);
    c = crc_ref(body);
    foreach (body[i]) f.push_back(body[i]);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
  endtask

  function automatic int frame_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic make_bytes(input int len, input int pat, output logic [7:0] d[$]);
    d = {};
    for (int i = 0; i < len; i++) d.push_back(pat == 0 ? 8'(i) : 8'($urandom));
  endtask

  task automatic send_and_check(input int len, input int pat, input int exp_bus,
                                input int exp_str, input int exp_drop, input string name);
    logic [7:0] d[$];
    logic [7:0] exp_f[$];
    int f0, s0, dr0, p0, n, lim;
    f0 = frames_done; s0 = strobes; dr0 = drops; p0 = pops;
    make_bytes(len, pat, d);
    if (exp_drop == 0) foreach (d[i]) memq.push_back(d[i]);
    lenq.push_back(LW'(len));
    n = 0;
    lim = exp_drop ? 100 : 4000;
    if (exp_drop) while (drops == dr0 && n < lim) begin @(negedge iclk); n++; end
    else          while (frames_done == f0 && n < lim) begin @(negedge iclk); n++; end
    repeat (20) @(negedge iclk);
    check({name, " finished"}, (n < lim) ? 1 : 0, 1);
    check({name, " pops"}, pops - p0, 1);
    check({name, " drops"}, drops - dr0, exp_drop);
    check({name, " strobes"}, strobes - s0, exp_str);
    check({name, " frames"}, frames_done - f0, exp_drop ? 0 : 1);
    if (exp_drop == 0) begin
      build_frame(d, exp_f);
      check({name, " bus bytes"}, last_frame.size(), exp_bus);
      check({name, " content diff idx"}, frame_diff(last_frame, exp_f), -1);
      check({name, " pop-to-tx cycles"}, lat, 1);
    end
  endtask

  typedef struct {
    int    len;
    int    pat;
    int    exp_bus;
    int    exp_str;
    int    exp_drop;
    string name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] d1[$], d2[$], e2[$];
    int f0, p0, s0, n, rl;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end

    vecs[0] = '{64,   0, 76,   64,   0, "len64_incr"};
    vecs[1] = '{10,   1, 72,   10,   0, "len10_pad"};
    vecs[2] = '{1,    1, 72,   1,    0, "len1"};
    vecs[3] = '{59,   1, 72,   59,   0, "len59"};
    vecs[4] = '{60,   1, 72,   60,   0, "len60"};
    vecs[5] = '{61,   1, 73,   61,   0, "len61"};
    vecs[6] = '{0,    1, 0,    0,    1, "len0_drop"};
    vecs[7] = '{1537, 1, 0,    0,    1, "len1537_drop"};
    vecs[8] = '{1536, 0, 1548, 1536, 0, "len1536_max"};
    vecs[9] = '{2047, 1, 0,    0,    1, "len2047_drop"};

    // Reset state
    repeat (3) @(negedge iclk);
    check("reset otx_en", otx_en, 0);
    check("reset otx_d", otx_d, 0);
    check("reset ord_en", ord_en, 0);
    check("reset pop/drop/busy/er", {opkt_pop, odrop, obusy, otx_er}, 0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge iclk);
    check("idle without valid", {obusy, otx_en, ord_en}, 0);

    for (int v = 0; v < 10; v++)
      send_and_check(vecs[v].len, vecs[v].pat, vecs[v].exp_bus, vecs[v].exp_str,
                     vecs[v].exp_drop, vecs[v].name);

    // Two back-to-back packets
    f0 = frames_done; p0 = pops;
    make_bytes(64, 1, d1);
    make_bytes(64, 1, d2);
    foreach (d1[i]) memq.push_back(d1[i]);
    foreach (d2[i]) memq.push_back(d2[i]);
    lenq.push_back(LW'(64));
    lenq.push_back(LW'(64));
    n = 0;
    while (frames_done < f0 + 2 && n < 1000) begin @(negedge iclk); n++; end
    repeat (20) @(negedge iclk);
    build_frame(d2, e2);
    check("b2b finished", (n < 1000) ? 1 : 0, 1);
    check("b2b pops", pops - p0, 2);
    check("b2b ifg low cycles", last_gap, 12);
    check("b2b second frame diff idx", frame_diff(last_frame, e2), -1);

    // Reset in the middle of DATA byte 20
    make_bytes(100, 1, d1);
    foreach (d1[i]) memq.push_back(d1[i]);
    lenq.push_back(LW'(100));
    n = 0;
    rl = 0;
    while (n < 300) begin
      @(posedge iclk); #1;
      n++;
      if (in_frame && cap.size() == 28) begin rl = 1; break; end
    end
    check("midframe reached byte 20", rl, 1);
    i_rst_n = 1'b0;
    #1;
    check("async reset otx_en", otx_en, 0);
    check("async reset otx_d", otx_d, 0);
    check("async reset ord_en", ord_en, 0);
    check("async reset busy/pop/drop", {obusy, opkt_pop, odrop}, 0);
    memq.delete();
    lenq.delete();
    s0 = strobes;
    repeat (5) @(negedge iclk);
    check("no strobes in reset", strobes - s0, 0);
    check("truncated frame bytes", last_frame.size(), 28);
    i_rst_n = 1'b1;
    repeat (3) @(negedge iclk);
    send_and_check(70, 1, 82, 70, 0, "post_reset");

    // Randomized lengths against the reference model
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 150);
      send_and_check(len, 1, 8 + ((len < 60) ? 60 : len) + 4, len, 0, "random");
    end

    check("read underruns", underrun, 0);
    check("otx_er high cycles", er_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
